dmem_wait_responder: RTL and testbench
======================================

// Module: dmem_wait_responder
// PURPOSE
//  Memory-side responder for the pipelined CPU's M-stage data port. It serves
//  word reads and writes from an internal RAM with a programmable wait-state
//  latency, and asserts a stall so the hazard unit freezes the pipeline until
//  each access completes. It sits between the CPU core's data port and the top
//  level, replacing the zero-latency data RAM.
// PARAMETERS
//  DEPTH_WORDS  1024  RAM depth in 32-bit words; power of two, >=2
//  WAIT_CYCLES  2     extra latency per access; legal range 1..15
//  ADDR_W       clog2(DEPTH_WORDS)  word-index width; derived, do not override
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  rst        in   1   reset; asynchronous, active-high
//  req_en     in   1   M-stage memory access valid (load or store)
//  req_we     in   1   1 = store, 0 = load; meaningful only with req_en=1
//  req_addr   in   32  byte address (CPU aluoutM)
//  req_wdata  in   32  store data (CPU writedataM)
//  rdata      out  32  load data (CPU readdataM), registered
//  stall      out  1   1 = hold pipeline; combinational from state and req_en
//  err        out  1   1-cycle access-error pulse (ADDR_CHECK_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, rdata=0, err=0. RAM contents are not cleared.
//  stall = req_en & (state != DONE). While stall=1, the CPU holds req_* stable.
//  Word index = req_addr[ADDR_W+1:2].
//  FSM (cnt is 4 bits):
//   IDLE: req_en=1 -> BUSY, cnt <= WAIT_CYCLES-1. req_en=0 -> stay in IDLE.
//   BUSY: req_en=0 (flushed) -> IDLE; no RAM write; rdata unchanged.
//         cnt!=0 -> cnt <= cnt-1.
//         cnt==0 -> perform access at this edge, then -> DONE.
//           Store: ram[idx] <= req_wdata.
//           Load:  rdata <= ram[idx].
//   DONE: stall=0, so the pipeline advances at this edge. Next state is IDLE
//         unconditionally. rdata holds the value until the next load completes.
//  Latency: stall=1 for exactly WAIT_CYCLES+1 cycles per access; the data is
//   valid in the cycle where stall first drops.
//  Back-to-back accesses: DONE->IDLE adds no extra bubble. The next request is
//   seen in IDLE one cycle after DONE, with stall=0 in the DONE cycle only.
//  Store then load to the same word: the load returns the stored value
//   (there is no write buffer).
//  Reset mid-access (IDLE/BUSY/DONE): return to IDLE immediately; a pending
//   write is discarded; stall falls with the state; rdata returns to 0.
//  In DONE, req_en may be 1 (it is the completing request); it is never
//   re-served.
// CONFIGURATION
//  DMEM_ADDR_CHECK_EN defined:
//   - An access is in error if req_addr[1:0]!=0, or if
//     req_addr[31:ADDR_W+2]!=0 (out of range).
//   - On completion of an errored access: the write is suppressed, rdata <= 0,
//     and err=1 for the DONE cycle only.
//   - Latency is unchanged.
//  DMEM_ADDR_CHECK_EN undefined:
//   - err is tied to 0.
//   - Low two address bits are ignored.
//   - High address bits are truncated, so out-of-range addresses alias.
// TESTING
//  1 Reset, WAIT_CYCLES=2; load addr 0x0 -> stall high 3 cycles, rdata=RAM init
//    value, err=0.
//  2 Store 0x0000_00C8 @0x10, then load @0x10 -> rdata=0x0000_00C8; each access
//    stalls 3 cycles, with 1 non-stall cycle between accesses.
//  3 Store 0xDEAD_BEEF @0x20; drop req_en in the 2nd BUSY cycle -> IDLE, stall
//    drops; a later load @0x20 returns the old value.
//  4 Assert rst during BUSY of a store @0x30 -> stall=0, rdata=0 asynchronously;
//    a load @0x30 after reset returns the pre-store value.
//  5 WAIT_CYCLES=1; 4 consecutive loads -> stall pattern 1,1,0 repeated, with
//    correct data on each 0 cycle.
//  6 DMEM_ADDR_CHECK_EN: store @0x0000_0002 -> err=1 in the DONE cycle, RAM
//    unchanged; load @(DEPTH_WORDS*4) -> rdata=0, err=1.
//    Without the macro, the same load returns ram[0] and err=0.

Source files
------------

// File: rtl/dmem_wait_responder.sv
// Wait-state data-memory responder for the CPU M stage: stalls the pipeline for WAIT_CYCLES+1 cycles per access.
// Optional address checking (misaligned / out-of-range -> err pulse) is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_wait_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              complete;
  logic              addr_err;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       ram [DEPTH_WORDS];

  assign idx = req_addr[ADDR_W+1:2];

`ifdef DMEM_ADDR_CHECK_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
`else
  // Low byte-offset bits and high bits are deliberately ignored; out-of-range addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (req_en) begin
          state_next = BUSY;
          cnt_next   = 4'(WAIT_CYCLES - 1);
        end
      end
      BUSY: begin
        // A dropped request means the pipeline flushed it; abandon without touching RAM.
        if (!req_en) begin
          state_next = IDLE;
        end else if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign stall = req_en && (state != DONE);

  always_ff @(posedge clk) begin
    if (complete && req_we && !addr_err) begin
      ram[idx] <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (complete) begin
      if (addr_err) begin
        rdata <= 32'd0;
      end else if (!req_we) begin
        rdata <= ram[idx];
      end
    end
  end

`ifdef DMEM_ADDR_CHECK_EN
  // err is high only in the DONE cycle that follows a faulty completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= complete && addr_err;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench for dmem_wait_responder: two instances (WAIT_CYCLES=2 and 1), directed accesses.
// Expectations for address-error cases follow DMEM_ADDR_CHECK_EN when it is defined.
module tb_dmem_wait_responder;

  localparam int WAIT_A  = 2;
  localparam int WAIT_B  = 1;
  localparam int DEPTH_B = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic        req_en_a, req_we_a, stall_a, err_a;
  logic [31:0] req_addr_a, req_wdata_a, rdata_a;
  logic        req_en_b, req_we_b, stall_b, err_b;
  logic [31:0] req_addr_b, req_wdata_b, rdata_b;

  dmem_wait_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .rst(rst), .req_en(req_en_a), .req_we(req_we_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rdata(rdata_a), .stall(stall_a), .err(err_a)
  );

  dmem_wait_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk(clk), .rst(rst), .req_en(req_en_b), .req_we(req_we_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rdata(rdata_b), .stall(stall_b), .err(err_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic        chk_data;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a;
  exp_t        e_b;
  int          n_pass  = 0;
  int          n_total = 0;
  int          run_a   = 0;
  int          run_b   = 0;
  logic [31:0] model_a = 32'd0;
  logic [31:0] model_b = 32'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic checkCompletion(input string tag, input exp_t e, input int run,
                                 input logic [31:0] rd, input logic er);
    checkOutput({tag, "_stall_cycles"}, 32'(run), 32'(e.lat));
    if (e.chk_data) checkOutput({tag, "_rdata"}, rd, e.rdata);
    checkOutput({tag, "_err"}, {31'd0, er}, {31'd0, e.err});
  endtask

  // Monitors: count stall cycles of the live request and score each completion (req_en & !stall).
  always @(negedge clk) begin
    if (rst || !req_en_a) begin
      run_a = 0;
    end else if (stall_a) begin
      run_a = run_a + 1;
    end else begin
      if (q_a.size() == 0) begin
        checkOutput("A_spurious_done", 32'(q_a.size()), 32'd1);
      end else begin
        e_a = q_a.pop_front();
        checkCompletion("A", e_a, run_a, rdata_a, err_a);
      end
      run_a = 0;
    end
  end

  always @(negedge clk) begin
    if (rst || !req_en_b) begin
      run_b = 0;
    end else if (stall_b) begin
      run_b = run_b + 1;
    end else begin
      if (q_b.size() == 0) begin
        checkOutput("B_spurious_done", 32'(q_b.size()), 32'd1);
      end else begin
        e_b = q_b.pop_front();
        checkCompletion("B", e_b, run_b, rdata_b, err_b);
      end
      run_b = 0;
    end
  end

  // Issue one access on instance u (0=A, 1=B); keep leaves req_en high for a back-to-back follow-up.
  task automatic applyStimulus(input int u, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic exp_err,
                               input logic [31:0] exp_rdata, input logic chk, input logic keep);
    exp_t        e;
    logic [31:0] m;
    logic        st;
    int          n;
    m = (u == 0) ? model_a : model_b;
    if (exp_err) m = 32'd0;
    else if (!we) m = exp_rdata;
    e.rdata    = m;
    e.err      = exp_err;
    e.lat      = ((u == 0) ? WAIT_A : WAIT_B) + 1;
    e.chk_data = chk;
    if (u == 0) begin
      model_a = m;
      q_a.push_back(e);
      req_en_a = 1'b1; req_we_a = we; req_addr_a = addr; req_wdata_a = wdata;
    end else begin
      model_b = m;
      q_b.push_back(e);
      req_en_b = 1'b1; req_we_b = we; req_addr_b = addr; req_wdata_b = wdata;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      st = (u == 0) ? stall_a : stall_b;
    end while (st && n < 40);
    checkOutput("access_completes", {31'd0, st}, 32'd0);
    if (st) begin
      if (u == 0) void'(q_a.pop_back());
      else void'(q_b.pop_back());
    end
    @(posedge clk); #1;
    if (!keep || st) begin
      if (u == 0) req_en_a = 1'b0;
      else req_en_b = 1'b0;
    end
  endtask

  // Store on A that is abandoned in its second BUSY cycle, by flush or by reset.
  task automatic abortAccess(input logic [31:0] addr, input logic [31:0] wdata, input logic use_reset);
    req_en_a = 1'b1; req_we_a = 1'b1; req_addr_a = addr; req_wdata_a = wdata;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort_stall_before", {31'd0, stall_a}, 32'd1);
    if (use_reset) begin
      rst = 1'b1; #1;
      checkOutput("reset_mid_rdata", rdata_a, 32'd0);
      req_en_a = 1'b0; #1;
      checkOutput("reset_mid_stall", {31'd0, stall_a}, 32'd0);
      model_a = 32'd0;
      model_b = 32'd0;
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      req_en_a = 1'b0; #1;
      checkOutput("flush_stall", {31'd0, stall_a}, 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    req_en_a = 1'b0; req_we_a = 1'b0; req_addr_a = 32'd0; req_wdata_a = 32'd0;
    req_en_b = 1'b0; req_we_b = 1'b0; req_addr_b = 32'd0; req_wdata_b = 32'd0;
    rst = 1'b1;
    #12;
    checkOutput("reset_rdata_a", rdata_a, 32'd0);
    checkOutput("reset_stall_a", {31'd0, stall_a}, 32'd0);
    checkOutput("reset_err_a", {31'd0, err_a}, 32'd0);
    checkOutput("reset_rdata_b", rdata_b, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // First load of an uninitialised word: only latency and err are known.
    applyStimulus(0, 1'b0, 32'h0000_0000, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Back-to-back store then load of the same word.
    applyStimulus(0, 1'b1, 32'h0000_0010, 32'h0000_00C8, 1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 32'h0000_0010, 32'd0, 1'b0, 32'h0000_00C8, 1'b1, 1'b0);

    // Flushed store leaves the old word intact.
    applyStimulus(0, 1'b1, 32'h0000_0020, 32'h0BAD_0020, 1'b0, 32'd0, 1'b1, 1'b0);
    abortAccess(32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'd0, 1'b0, 32'h0BAD_0020, 1'b1, 1'b0);

    // Reset during a store discards it and clears rdata.
    applyStimulus(0, 1'b1, 32'h0000_0030, 32'h1111_3030, 1'b0, 32'd0, 1'b1, 1'b0);
    abortAccess(32'h0000_0030, 32'hBAD0_3030, 1'b1);
    applyStimulus(0, 1'b0, 32'h0000_0030, 32'd0, 1'b0, 32'h1111_3030, 1'b1, 1'b0);

    // WAIT_CYCLES=1 instance: preload then four consecutive loads (stall 1,1,0 each).
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1'b1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1'b0, 32'(i * 4), 32'd0, 1'b0, 32'hB000_0000 + 32'(i), 1'b1, (i < 3));

    // Misaligned and out-of-range addresses.
    applyStimulus(0, 1'b1, 32'h0000_0000, 32'h5A5A_0000, 1'b0, 32'd0, 1'b1, 1'b0);
`ifdef DMEM_ADDR_CHECK_EN
    applyStimulus(0, 1'b1, 32'h0000_0002, 32'h1234_5678, 1'b1, 32'd0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0000, 32'd0, 1'b0, 32'h5A5A_0000, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_1000, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0);
`else
    applyStimulus(0, 1'b1, 32'h0000_0002, 32'h1234_5678, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_0000, 32'd0, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
    applyStimulus(0, 1'b0, 32'h0000_1000, 32'd0, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_a_drained", 32'(q_a.size()), 32'd0);
    checkOutput("scoreboard_b_drained", 32'(q_b.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
